// File: rtl/axis_to_xmii_pkg.sv
// Shared types and constants for the AXIS-to-xMII transmitter.
// Optional FCS generation is enabled by defining AXIS_TO_XMII_TX_FCS_EN.
package axis_to_xmii_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_ERROR    = 3'd3,
        S_DRAIN    = 3'd4,
        S_IFG      = 3'd5
`ifdef AXIS_TO_XMII_TX_FCS_EN
        , S_FCS    = 3'd6
`endif
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          PREAMBLE_LEN    = 8;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // FCS goes out as the complemented CRC, least significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] fcs;
        fcs = ~crc;
        case (idx)
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            2'd3:    fcs_byte = fcs[31:24];
            default: fcs_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/axis_to_xmii_tx_crc32_d8.sv
// Combinational byte-wise reflected CRC-32 step (Ethernet FCS polynomial).
module crc32_d8
    import axis_to_xmii_pkg::*;
(
    input  logic [7:0]  data_i,
    input  logic [31:0] crc_i,
    output logic [31:0] crc_o
);

    logic [31:0] work_s;

    // Shift the byte through the reflected polynomial one bit at a time.
    always_comb begin
        work_s = crc_i ^ {24'h000000, data_i};
        for (int i = 0; i < 8; i++) begin
            if (work_s[0]) begin
                work_s = (work_s >> 1) ^ CRC32_POLY_REFL;
            end else begin
                work_s = work_s >> 1;
            end
        end
        crc_o = work_s;
    end

endmodule

// File: rtl/axis_to_xmii_tx.sv
// AXI4-Stream byte to RMII/MII/GMII transmit serialiser with preamble, IFG and underrun handling.
// Define AXIS_TO_XMII_TX_FCS_EN to append a CRC-32 FCS after the payload.
module axis_to_xmii_tx
    import axis_to_xmii_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int PREAMBLE_EN = 1,
    parameter int IFG_BYTES   = 12
) (
    input  logic                  clock,
    input  logic                  aresetn,
    input  logic [7:0]            saxis_tdata,
    input  logic                  saxis_tvalid,
    output logic                  saxis_tready,
    input  logic                  saxis_tlast,
    output logic [DATA_WIDTH-1:0] xmii_d,
    output logic                  xmii_en,
    output logic                  xmii_er,
    output logic                  tx_busy,
    output logic                  underrun
);

    localparam int          BEATS     = 8 / DATA_WIDTH;
    localparam logic [1:0]  BEAT_LAST = 2'(BEATS - 1);
    localparam logic [2:0]  PRE_LAST  = 3'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES * BEATS - 1);

    if (!(DATA_WIDTH == 2 || DATA_WIDTH == 4 || DATA_WIDTH == 8)) begin : g_bad_width
        $error("axis_to_xmii_tx: DATA_WIDTH must be 2, 4 or 8");
    end
    if (IFG_BYTES < 1 || IFG_BYTES > 255) begin : g_bad_ifg
        $error("axis_to_xmii_tx: IFG_BYTES must be in 1..255");
    end

    state_t                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [15:0]           ifg_q, ifg_d;
    logic [7:0]            byte_q, byte_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] xmii_d_q, xmii_d_d;
    logic                  en_q, en_d;
    logic                  er_q, er_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;

    logic       tready_s;
    logic       hs_s;
    logic       beat_last_s;
    logic [7:0] cur_byte_s;
    logic [7:0] shifted_s;
    logic [2:0] off_s;

    assign beat_last_s  = (beat_q == BEAT_LAST);
    assign hs_s         = saxis_tvalid && tready_s;
    assign saxis_tready = tready_s;
    assign xmii_d       = xmii_d_q;
    assign xmii_en      = en_q;
    assign xmii_er      = er_q;
    assign tx_busy      = busy_q;
    assign underrun     = underrun_q;

`ifdef AXIS_TO_XMII_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_base_s, crc_next_s;

    assign crc_base_s = (state_q == S_IDLE) ? CRC32_INIT : crc_q;

    crc32_d8 u_crc (
        .data_i (saxis_tdata),
        .crc_i  (crc_base_s),
        .crc_o  (crc_next_s)
    );

    // Accumulate over payload bytes only; re-arm while idle.
    always_comb begin
        if (hs_s && (state_q == S_IDLE || state_q == S_DATA)) begin
            crc_d = crc_next_s;
        end else if (state_q == S_IDLE) begin
            crc_d = CRC32_INIT;
        end else begin
            crc_d = crc_q;
        end
    end
`endif

    // Upstream may only hand over a byte when the held one is on its final beat.
    always_comb begin
        case (state_q)
            S_IDLE:  tready_s = 1'b1;
            S_DATA:  tready_s = beat_last_s && !last_q;
            S_DRAIN: tready_s = 1'b1;
            default: tready_s = 1'b0;
        endcase
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        ifg_d      = ifg_q;
        byte_d     = byte_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    byte_d  = saxis_tdata;
                    last_d  = saxis_tlast;
                    beat_d  = 2'd0;
                    cnt_d   = 3'd0;
                    state_d = (PREAMBLE_EN != 0) ? S_PREAMBLE : S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (!beat_last_s) begin
                    beat_d = beat_q + 2'd1;
                end else if (cnt_q == PRE_LAST) begin
                    beat_d  = 2'd0;
                    cnt_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    beat_d = 2'd0;
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            S_DATA: begin
                if (!beat_last_s) begin
                    beat_d = beat_q + 2'd1;
                end else if (hs_s) begin
                    byte_d = saxis_tdata;
                    last_d = saxis_tlast;
                    beat_d = 2'd0;
                end else if (last_q) begin
                    beat_d = 2'd0;
                    cnt_d  = 3'd0;
                    ifg_d  = 16'd0;
`ifdef AXIS_TO_XMII_TX_FCS_EN
                    state_d = S_FCS;
`else
                    state_d = S_IFG;
`endif
                end else begin
                    beat_d     = 2'd0;
                    underrun_d = 1'b1;
                    state_d    = S_ERROR;
                end
            end
            S_ERROR: begin
                if (beat_last_s) begin
                    beat_d  = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (hs_s && saxis_tlast) begin
                    ifg_d   = 16'd0;
                    state_d = S_IFG;
                end else begin
                    state_d = S_DRAIN;
                end
            end
`ifdef AXIS_TO_XMII_TX_FCS_EN
            S_FCS: begin
                if (!beat_last_s) begin
                    beat_d = beat_q + 2'd1;
                end else if (cnt_q == 3'd3) begin
                    beat_d  = 2'd0;
                    ifg_d   = 16'd0;
                    state_d = S_IFG;
                end else begin
                    beat_d = 2'd0;
                    cnt_d  = cnt_q + 3'd1;
                end
            end
`endif
            S_IFG: begin
                if (ifg_q == IFG_LAST) begin
                    ifg_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    ifg_d = ifg_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the bus lines up with the state it represents.
    always_comb begin
        case (state_d)
            S_PREAMBLE: cur_byte_s = (cnt_d == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            S_DATA:     cur_byte_s = byte_d;
`ifdef AXIS_TO_XMII_TX_FCS_EN
            S_FCS:      cur_byte_s = fcs_byte(crc_q, cnt_d[1:0]);
`endif
            default:    cur_byte_s = 8'h00;
        endcase
        case (state_d)
            S_PREAMBLE, S_DATA, S_ERROR: en_d = 1'b1;
`ifdef AXIS_TO_XMII_TX_FCS_EN
            S_FCS:                       en_d = 1'b1;
`endif
            default:                     en_d = 1'b0;
        endcase
        off_s     = 3'(int'(beat_d) * DATA_WIDTH);
        shifted_s = cur_byte_s >> off_s;
        xmii_d_d  = shifted_s[DATA_WIDTH-1:0];
        er_d      = (state_d == S_ERROR);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            beat_q     <= 2'd0;
            cnt_q      <= 3'd0;
            ifg_q      <= 16'd0;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            xmii_d_q   <= '0;
            en_q       <= 1'b0;
            er_q       <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef AXIS_TO_XMII_TX_FCS_EN
            crc_q      <= CRC32_INIT;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            ifg_q      <= ifg_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            xmii_d_q   <= xmii_d_d;
            en_q       <= en_d;
            er_q       <= er_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
`ifdef AXIS_TO_XMII_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

endmodule

// File: doc/axis_to_xmii_tx.md
Name: axis_to_xmii_tx

Overview:
- Parametrised AXI4-Stream byte-to-MII-family transmitter.
- Serialises 8-bit AXIS frames onto a DATA_WIDTH-bit xMII bus: RMII 2-bit, MII 4-bit or GMII 8-bit.
- Optionally inserts preamble/SFD, enforces a programmable inter-frame gap, flags underrun on xmii_er.
- Sits between the MAC frame builder (AXIS master) and the PHY pads.

Parameters:
- DATA_WIDTH, 4, xMII data width; legal values 2, 4, 8 (elaboration error otherwise).
- PREAMBLE_EN, 1, 1: emit 7×0x55 + 0xD5 before payload; 0: payload starts immediately.
- IFG_BYTES, 12, inter-frame gap in byte times; legal range 1..255.

Ports:
- clock  in  1  transmit clock, one xMII beat per cycle
- aresetn  in  1  synchronous reset, active-low
- saxis_tdata  in  8  frame byte
- saxis_tvalid  in  1  byte valid
- saxis_tready  out  1  byte accepted when tvalid&&tready
- saxis_tlast  in  1  last byte of frame
- xmii_d  out  DATA_WIDTH  transmit data, LSB-first slice of the current byte
- xmii_en  out  1  transmit enable
- xmii_er  out  1  transmit error
- tx_busy  out  1  high in every state except S_IDLE
- underrun  out  1  one-cycle pulse when an underrun is detected

Behaviour:
- Reset, clock and bus: reset aresetn, synchronous, active-low; clock clock.
- Reset values: xmii_d=0, xmii_en=0, xmii_er=0, underrun=0, state S_IDLE, all counters 0.
- Registered outputs: xmii_d, xmii_en, xmii_er, underrun, tx_busy.
- Combinational output: saxis_tready, decoded from state and counters.
- Byte serialisation:
  - BEATS = 8/DATA_WIDTH.
  - Beat k of a byte drives byte[k*DATA_WIDTH +: DATA_WIDTH].
  - Beat counter beat wraps at BEATS-1.
- States: S_IDLE, S_PREAMBLE, S_DATA, S_ERROR, S_DRAIN, S_IFG.
- S_IDLE:
  - tready=1.
  - On handshake, latch the byte and tlast; go to S_PREAMBLE (PREAMBLE_EN=1) or S_DATA.
  - First xmii_en rises on the cycle after the handshake.
- S_PREAMBLE:
  - Emit 8 bytes (7×0x55, then 0xD5) = 8*BEATS cycles, xmii_en=1.
  - Then go to S_DATA; the latched first byte is held throughout.
- S_DATA:
  - Emit the held byte.
  - On its last beat (beat==BEATS-1), tready = !held_tlast.
  - Handshake on that beat: load the next byte, stay in S_DATA, no bubble.
  - held_tlast=1: go to S_IFG.
  - held_tlast=0 and tvalid=0: underrun. Pulse underrun, go to S_ERROR.
- S_ERROR:
  - For BEATS cycles drive xmii_en=1, xmii_er=1, xmii_d=0.
  - Then go to S_DRAIN.
- S_DRAIN:
  - xmii_en=0, tready=1; discard bytes.
  - Go to S_IFG on the cycle a byte with tlast=1 is accepted.
- S_IFG:
  - xmii_en=0, tready=0 for IFG_BYTES*BEATS cycles; counter width 16 bits.
  - Then go to S_IDLE.
- Back-to-back frames: minimum gap is exactly IFG_BYTES*BEATS cycles with xmii_en=0, plus 1 idle-accept cycle.
- Single-byte frame (tlast on first byte): legal; preamble + 1 byte, then S_IFG.
- Reset mid-frame: outputs return to reset values at the next edge; the partial frame is abandoned and not resumed. Upstream is responsible for dropping the remainder.
- tvalid deasserted in S_IDLE or S_IFG: no effect.

Optional Feature:
- Macro: AXIS_TO_XMII_TX_FCS_EN.
- Defined:
  - Adds state S_FCS.
  - Byte-wise CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement) accumulates over payload bytes only.
  - After the last payload byte, 4 FCS bytes follow LSB-first, then S_IFG.
  - CRC resets in S_IDLE.
  - Underrun suppresses FCS.
- Undefined: no S_FCS state, no CRC logic; the frame ends after the last payload byte.

Decomposition:
- Package axis_to_xmii_pkg holds:
  - state_t enum;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=8, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT.
- Sub-module crc32_d8:
  - Combinational next-CRC from 8-bit data plus current CRC.
  - Instantiated only under AXIS_TO_XMII_TX_FCS_EN.

Test Plan:
- MII, PREAMBLE_EN=1, frame {0xA5,0x3C} → xmii_d: 14 cycles of 5, 1 cycle of 5, 1 cycle of D, then 5,A,C,3; xmii_en high exactly 20 cycles; then 24 cycles en=0.
- GMII, PREAMBLE_EN=0, 3-byte frame 0x01,0x02,0x03 with tvalid held → xmii_d 01,02,03 on consecutive cycles; tready high on each byte's single beat; no bubbles.
- MII, underrun: tvalid drops after byte 2 of 5 → underrun pulse; 2 cycles en=1/er=1; en=0; remaining bytes consumed by tready=1 until tlast; then IFG.
- RMII, back-to-back frames with IFG_BYTES=12 → exactly 48 en=0 cycles between frames (+1 accept cycle).
- Reset asserted mid-payload → next edge xmii_en=0, xmii_er=0, tx_busy=0; the following frame transmits cleanly with preamble.
- FCS_EN, GMII, payload ASCII "123456789" → trailing bytes 26,39,F4,CB; en drops after them.
